// File: rtl/oled_ssd1306_ctrl.sv
// SSD1306-compatible SPI command/data controller: deserialises the AVR OLED stream,
// runs the command set, tracks the column/page pointers and writes bytes to the framebuffer.
module oled_ssd1306_ctrl #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned IDLE_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       oled_clk_i,
  input  logic       oled_dc_i,
  input  logic       oled_data_i,
  output logic       fb_req_o,
  input  logic       fb_ack_i,
  output logic [9:0] fb_addr_o,
  output logic [7:0] fb_wdata_o,
  output logic       display_on_o,
  output logic       invert_o,
  output logic [7:0] contrast_o,
  output logic       overrun_o
);

  localparam int unsigned COL_W  = 7;
  localparam int unsigned PAGE_W = 3;
  localparam int unsigned ADDR_W = COL_W + PAGE_W;

  typedef enum logic [1:0] {ST_IDLE, ST_ARG1, ST_ARG2} state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, dc_sync_q, mosi_sync_q;
  logic                   scl_prev_q;
  logic [6:0]             shift_q;
  logic [2:0]             bitcnt_q;
  logic [7:0]             idle_q;

  logic scl_s, dc_s, mosi_s, scl_rise, byte_done, is_data, is_cmd;
  logic [7:0] byte_c;

  state_e state_q, state_d;

  logic              fb_req_q, fb_req_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]        fb_wdata_q, fb_wdata_d;
  logic              disp_q, disp_d, inv_q, inv_d, overrun_q, overrun_d;
  logic [7:0]        contrast_q, contrast_d, cmd_q, cmd_d;
  logic [6:0]        arg1_q, arg1_d;
  logic [1:0]        mode_q, mode_d;
  logic [COL_W-1:0]  col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d, col_inc;
  logic [PAGE_W-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d, page_inc;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign dc_s      = dc_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign byte_done = scl_rise && (bitcnt_q == 3'd7);
  assign byte_c    = {shift_q, mosi_s};
  assign is_data   = byte_done & dc_s;
  assign is_cmd    = byte_done & ~dc_s;

  // Synchronisers, bit assembly and idle-timeout for a stalled partial byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q  <= '0;
      dc_sync_q   <= '0;
      mosi_sync_q <= '0;
      scl_prev_q  <= 1'b0;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      idle_q      <= '0;
    end else begin
      scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], oled_clk_i};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], oled_dc_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], oled_data_i};
      scl_prev_q  <= scl_s;
      if (scl_rise) begin
        shift_q  <= {shift_q[5:0], mosi_s};
        bitcnt_q <= bitcnt_q + 3'd1;
        idle_q   <= '0;
      end else if (idle_q == 8'(IDLE_TIMEOUT)) begin
        bitcnt_q <= '0;
      end else begin
        idle_q <= idle_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Command sequencing; a data byte always abandons a half-received command
  always_comb begin
    state_d = state_q;
    if (is_data) begin
      state_d = ST_IDLE;
    end else if (is_cmd) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_c == 8'h20 || byte_c == 8'h21 || byte_c == 8'h22 || byte_c == 8'h81)
            state_d = ST_ARG1;
        end
        ST_ARG1: state_d = (cmd_q == 8'h21 || cmd_q == 8'h22) ? ST_ARG2 : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign col_inc  = (col_q == col_end_q) ? col_start_q : col_q + 7'd1;
  assign page_inc = (page_q == page_end_q) ? page_start_q : page_q + 3'd1;

  always_comb begin
    fb_req_d     = fb_req_q;
    fb_addr_d    = fb_addr_q;
    fb_wdata_d   = fb_wdata_q;
    disp_d       = disp_q;
    inv_d        = inv_q;
    contrast_d   = contrast_q;
    overrun_d    = overrun_q;
    cmd_d        = cmd_q;
    arg1_d       = arg1_q;
    mode_d       = mode_q;
    col_d        = col_q;
    page_d       = page_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;

    if (fb_req_q && fb_ack_i) fb_req_d = 1'b0;

    if (is_data) begin
      if (fb_req_q) begin
        overrun_d = 1'b1;
      end else begin
        fb_req_d   = 1'b1;
        fb_addr_d  = {page_q, col_q};
        fb_wdata_d = byte_c;
        case (mode_q)
          2'd0: begin
            col_d = col_inc;
            if (col_q == col_end_q) page_d = page_inc;
          end
          2'd1: begin
            page_d = page_inc;
            if (page_q == page_end_q) col_d = col_inc;
          end
          default: col_d = col_inc;
        endcase
      end
    end else if (is_cmd) begin
      case (state_q)
        ST_IDLE: begin
          cmd_d = byte_c;
          if (byte_c[7:4] == 4'h0)         col_d[3:0] = byte_c[3:0];
          else if (byte_c[7:3] == 5'b00010) col_d[6:4] = byte_c[2:0];
          else if (byte_c[7:3] == 5'b10110) page_d     = byte_c[2:0];
          else begin
            case (byte_c)
              8'hAE:   disp_d = 1'b0;
              8'hAF:   disp_d = 1'b1;
              8'hA6:   inv_d  = 1'b0;
              8'hA7:   inv_d  = 1'b1;
              default: ;
            endcase
          end
        end
        ST_ARG1: begin
          arg1_d = byte_c[6:0];
          if (cmd_q == 8'h20) mode_d = (byte_c[1:0] == 2'd3) ? 2'd2 : byte_c[1:0];
          if (cmd_q == 8'h81) contrast_d = byte_c;
        end
        ST_ARG2: begin
          if (cmd_q == 8'h21) begin
            col_start_d = arg1_q;
            col_end_d   = byte_c[6:0];
            col_d       = arg1_q;
          end else begin
            page_start_d = arg1_q[2:0];
            page_end_d   = byte_c[2:0];
            page_d       = arg1_q[2:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_req_q     <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
      disp_q       <= 1'b0;
      inv_q        <= 1'b0;
      contrast_q   <= 8'h7F;
      overrun_q    <= 1'b0;
      cmd_q        <= '0;
      arg1_q       <= '0;
      mode_q       <= 2'd2;
      col_q        <= '0;
      page_q       <= '0;
      col_start_q  <= '0;
      col_end_q    <= 7'd127;
      page_start_q <= '0;
      page_end_q   <= 3'd7;
    end else begin
      fb_req_q     <= fb_req_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
      disp_q       <= disp_d;
      inv_q        <= inv_d;
      contrast_q   <= contrast_d;
      overrun_q    <= overrun_d;
      cmd_q        <= cmd_d;
      arg1_q       <= arg1_d;
      mode_q       <= mode_d;
      col_q        <= col_d;
      page_q       <= page_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
    end
  end

  assign fb_req_o     = fb_req_q;
  assign fb_addr_o    = fb_addr_q;
  assign fb_wdata_o   = fb_wdata_q;
  assign display_on_o = disp_q;
  assign invert_o     = inv_q;
  assign contrast_o   = contrast_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_oled_ssd1306_ctrl.sv
// Bench for oled_ssd1306_ctrl: serial byte driver, auto-ack framebuffer responder,
// a table of command vectors, directed corner cases and a random run against a byte-level model.
module tb_oled_ssd1306_ctrl;

  localparam int unsigned IDLE_TIMEOUT = 255;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       oled_clk = 1'b0, oled_dc = 1'b0, oled_data = 1'b0, fb_ack = 1'b0;
  logic       fb_req, display_on, invert, overrun;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata, contrast;

  oled_ssd1306_ctrl #(.SYNC_STAGES(2), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .oled_clk_i(oled_clk), .oled_dc_i(oled_dc), .oled_data_i(oled_data),
    .fb_req_o(fb_req), .fb_ack_i(fb_ack), .fb_addr_o(fb_addr), .fb_wdata_o(fb_wdata),
    .display_on_o(display_on), .invert_o(invert), .contrast_o(contrast), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  int   checks = 0, failures = 0;
  bit   ack_en = 1'b0;
  logic [17:0] act_q[$];
  logic [17:0] exp_q[$];

  // Byte-level reference model state
  int m_mode, m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_disp, m_inv, m_con, m_ovr, m_pend;
  int m_cmd[$];

  typedef struct {
    bit         dc;
    logic [7:0] b;
    bit         disp;
    bit         inv;
    logic [7:0] con;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Acknowledges one cycle after seeing a request and logs the accepted write
  initial forever begin
    @(negedge clk);
    if (ack_en && fb_req && !fb_ack) begin
      act_q.push_back({fb_addr, fb_wdata});
      fb_ack = 1'b1;
    end else begin
      fb_ack = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1);
  end

  task automatic model_reset();
    m_mode = 2; m_col = 0; m_page = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_disp = 0; m_inv = 0; m_con = 8'h7F; m_ovr = 0; m_pend = 0;
    m_cmd.delete();
  endtask

  task automatic model_advance();
    if (m_mode == 0) begin
      if (m_col == m_ce) begin
        m_col = m_cs;
        m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
      end else m_col = (m_col + 1) % 128;
    end else if (m_mode == 1) begin
      if (m_page == m_pe) begin
        m_page = m_ps;
        m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
      end else m_page = (m_page + 1) % 8;
    end else begin
      m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
    end
  endtask

  task automatic model_byte(input bit dc, input int b);
    int need;
    if (dc) begin
      m_cmd.delete();
      if (m_pend != 0) m_ovr = 1;
      else begin
        exp_q.push_back({10'(m_page * 128 + m_col), 8'(b)});
        if (!ack_en) m_pend = 1;
        model_advance();
      end
    end else begin
      m_cmd.push_back(b);
      need = (m_cmd[0] == 'h21 || m_cmd[0] == 'h22) ? 3 :
             (m_cmd[0] == 'h20 || m_cmd[0] == 'h81) ? 2 : 1;
      if (m_cmd.size() == need) begin
        case (m_cmd[0])
          'h20: m_mode = (m_cmd[1] % 4 == 3) ? 2 : m_cmd[1] % 4;
          'h21: begin m_cs = m_cmd[1] % 128; m_ce = m_cmd[2] % 128; m_col = m_cs; end
          'h22: begin m_ps = m_cmd[1] % 8; m_pe = m_cmd[2] % 8; m_page = m_ps; end
          'h81: m_con = m_cmd[1];
          'hAE: m_disp = 0;
          'hAF: m_disp = 1;
          'hA6: m_inv = 0;
          'hA7: m_inv = 1;
          default: begin
            if (b <= 'h0F) m_col = (m_col / 16) * 16 + b;
            else if (b >= 'h10 && b <= 'h17) m_col = (b - 'h10) * 16 + m_col % 16;
            else if (b >= 'hB0 && b <= 'hB7) m_page = b - 'hB0;
          end
        endcase
        m_cmd.delete();
      end
    end
  endtask

  task automatic send_bit(input bit dc, input bit v);
    @(negedge clk);
    oled_clk = 1'b0; oled_dc = dc; oled_data = v;
    @(negedge clk);
    @(negedge clk);
    oled_clk = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input bit dc, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(dc, b[i]);
    @(negedge clk);
    oled_clk = 1'b0;
    repeat (6) @(negedge clk);
    model_byte(dc, int'(b));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; oled_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic pop_chk(input string name, input int exp_addr, input int exp_data);
    logic [17:0] w;
    chk({name, "_present"}, int'(act_q.size() > 0), 1);
    if (act_q.size() > 0) begin
      w = act_q.pop_front();
      chk({name, "_addr"}, int'(w[17:8]), exp_addr);
      chk({name, "_data"}, int'(w[7:0]), exp_data);
    end
  endtask

  task automatic check_model(input string name);
    logic [17:0] a, e;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      chk({name, "_write"}, int'(a), int'(e));
    end
    chk({name, "_wr_count"}, act_q.size(), exp_q.size());
    act_q.delete();
    exp_q.delete();
    chk({name, "_disp"}, int'(display_on), m_disp);
    chk({name, "_inv"}, int'(invert), m_inv);
    chk({name, "_contrast"}, int'(contrast), m_con);
    chk({name, "_overrun"}, int'(overrun), m_ovr);
  endtask

  initial begin
    logic [7:0] b;
    int addrs3[5];
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_fb_req_low", int'(fb_req), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_fb_req", int'(fb_req), 0);
    chk("rst_fb_addr", int'(fb_addr), 0);
    chk("rst_fb_wdata", int'(fb_wdata), 0);
    chk("rst_display_on", int'(display_on), 0);
    chk("rst_invert", int'(invert), 0);
    chk("rst_contrast", int'(contrast), 'h7F);
    chk("rst_overrun", int'(overrun), 0);

    // Command table: status after each byte
    vt[0] = '{1'b0, 8'hAF, 1'b1, 1'b0, 8'h7F};
    vt[1] = '{1'b0, 8'hA7, 1'b1, 1'b1, 8'h7F};
    vt[2] = '{1'b0, 8'h81, 1'b1, 1'b1, 8'h7F};
    vt[3] = '{1'b0, 8'h20, 1'b1, 1'b1, 8'h20};
    vt[4] = '{1'b0, 8'hE3, 1'b1, 1'b1, 8'h20};
    vt[5] = '{1'b0, 8'hAE, 1'b0, 1'b1, 8'h20};
    vt[6] = '{1'b0, 8'hA6, 1'b0, 1'b0, 8'h20};
    vt[7] = '{1'b0, 8'h81, 1'b0, 1'b0, 8'h20};
    vt[8] = '{1'b1, 8'h5A, 1'b0, 1'b0, 8'h20};
    vt[9] = '{1'b0, 8'hA7, 1'b0, 1'b1, 8'h20};
    ack_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_byte(vt[i].dc, vt[i].b);
      chk($sformatf("vec%0d_disp", i), int'(display_on), int'(vt[i].disp));
      chk($sformatf("vec%0d_inv", i), int'(invert), int'(vt[i].inv));
      chk($sformatf("vec%0d_contrast", i), int'(contrast), int'(vt[i].con));
    end
    pop_chk("vec_abort_data", 0, 'h5A);

    // Direct page/column addressing
    do_reset();
    send_byte(1'b0, 8'hB3); send_byte(1'b0, 8'h05); send_byte(1'b0, 8'h12);
    send_byte(1'b1, 8'hA5);
    pop_chk("page_col_cmds", 'h1A5, 'hA5);

    // Vertical mode inside a 2x2 window
    do_reset();
    send_byte(1'b0, 8'h20); send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h21); send_byte(1'b0, 8'd10); send_byte(1'b0, 8'd11);
    send_byte(1'b0, 8'h22); send_byte(1'b0, 8'd6);  send_byte(1'b0, 8'd7);
    addrs3 = '{6*128+10, 7*128+10, 6*128+11, 7*128+11, 6*128+10};
    for (int i = 0; i < 5; i++) begin
      send_byte(1'b1, 8'(8'h30 + i));
      pop_chk($sformatf("vert%0d", i), addrs3[i], 'h30 + i);
    end

    // Stalled framebuffer: second byte is dropped
    do_reset();
    ack_en = 1'b0;
    send_byte(1'b1, 8'h11);
    send_byte(1'b1, 8'h22);
    chk("stall_req", int'(fb_req), 1);
    chk("stall_addr", int'(fb_addr), 0);
    chk("stall_wdata", int'(fb_wdata), 'h11);
    chk("stall_overrun", int'(overrun), 1);
    ack_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("stall_req_cleared", int'(fb_req), 0);
    pop_chk("stall_first", 0, 'h11);
    send_byte(1'b1, 8'h55);
    pop_chk("stall_next", 1, 'h55);
    chk("stall_overrun_sticky", int'(overrun), 1);

    // Data byte aborts a pending contrast argument
    do_reset();
    send_byte(1'b0, 8'h81);
    send_byte(1'b1, 8'h33);
    chk("abort_contrast", int'(contrast), 'h7F);
    pop_chk("abort_data", 0, 'h33);
    send_byte(1'b0, 8'h81); send_byte(1'b0, 8'h40);
    chk("contrast_set", int'(contrast), 'h40);

    // Full-screen horizontal fill
    do_reset();
    send_byte(1'b0, 8'h20); send_byte(1'b0, 8'h00);
    send_byte(1'b0, 8'h21); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h7F);
    send_byte(1'b0, 8'h22); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h07);
    for (int i = 0; i < 1024; i++) send_byte(1'b1, 8'(i) ^ 8'h5A);
    chk("fill_count", act_q.size(), 1024);
    for (int i = 0; i < 1024 && act_q.size() > 0; i++) begin
      logic [17:0] w;
      w = act_q.pop_front();
      chk($sformatf("fill_addr%0d", i), int'(w[17:8]), i);
      chk($sformatf("fill_data%0d", i), int'(w[7:0]), (i % 256) ^ 'h5A);
    end
    send_byte(1'b1, 8'hC3);
    pop_chk("fill_wrap", 0, 'hC3);
    chk("fill_overrun", int'(overrun), 0);

    // Random commands/data against the model
    do_reset();
    for (int n = 0; n < 160; n++) begin
      int r;
      bit dc;
      r = $urandom_range(0, 9);
      dc = 1'b0;
      case (r)
        0, 1, 2, 3: begin dc = 1'b1; b = 8'($urandom); end
        4: case ($urandom_range(0, 3))
             0: b = 8'h20; 1: b = 8'h21; 2: b = 8'h22; default: b = 8'h81;
           endcase
        5: case ($urandom_range(0, 3))
             0: b = 8'hAE; 1: b = 8'hAF; 2: b = 8'hA6; default: b = 8'hA7;
           endcase
        6: b = 8'(8'hB0 + $urandom_range(0, 7));
        7: b = 8'($urandom_range(0, 'h17));
        default: b = 8'($urandom);
      endcase
      send_byte(dc, b);
      check_model($sformatf("rnd%0d", n));
    end

    // Partial byte discarded after the idle timeout
    do_reset();
    send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b1);
    @(negedge clk);
    oled_clk = 1'b0;
    repeat (IDLE_TIMEOUT + 10) @(negedge clk);
    send_byte(1'b0, 8'hAF);
    chk("timeout_display_on", int'(display_on), 1);
    chk("timeout_no_write", int'(fb_req), 0);

    // Asynchronous reset while a write is pending
    ack_en = 1'b0;
    send_byte(1'b1, 8'h77);
    chk("pre_reset_req", int'(fb_req), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_req", int'(fb_req), 0);
    chk("async_reset_display", int'(display_on), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
